// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode hex display driver with a per-frame input snapshot.
// Optional feature macro: LEADING_ZERO_SUPPRESS_EN (blank leading zero digits).
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS        = 8,
  parameter int DIGIT_HOLD_CYCLES = 100000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp_mask,
  input  logic [NUM_DIGITS-1:0]     blank_mask,
  output logic [6:0]                a_to_g_n,
  output logic                      dp_n,
  output logic [NUM_DIGITS-1:0]     an_n,
  output logic                      frame_tick
);

  localparam int CW = $clog2(DIGIT_HOLD_CYCLES);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIGIT_HOLD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  // Hex nibble to active-low ABCDEFG (bit6 = A).
  function automatic logic [6:0] decode_hex(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b0000001;
      4'h1:    seg = 7'b1001111;
      4'h2:    seg = 7'b0010010;
      4'h3:    seg = 7'b0000110;
      4'h4:    seg = 7'b1001100;
      4'h5:    seg = 7'b0100100;
      4'h6:    seg = 7'b0100000;
      4'h7:    seg = 7'b0001111;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0000100;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b1100000;
      4'hC:    seg = 7'b0110001;
      4'hD:    seg = 7'b1000010;
      4'hE:    seg = 7'b0110000;
      4'hF:    seg = 7'b0111000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  logic [CW-1:0]             cnt_r;
  logic [IW-1:0]             idx_r;
  logic [4*NUM_DIGITS-1:0]   value_snap_r;
  logic [NUM_DIGITS-1:0]     dp_snap_r;
  logic [NUM_DIGITS-1:0]     blank_snap_r;

  logic                      term_s;
  logic                      frame_end_s;
  logic [3:0]                nibble_s;
  logic                      dp_bit_s;
  logic                      blank_bit_s;
  logic                      lz_bit_s;
  logic [NUM_DIGITS-1:0]     an_s;
  logic [NUM_DIGITS-1:0]     lz_s;
  logic                      zero_run_s;

  // Terminal-count and end-of-frame detection.
  always_comb begin
    term_s      = (cnt_r == CNT_MAX);
    frame_end_s = term_s && (idx_r == IDX_MAX);
  end

  // Select the current digit's nibble, flags and anode pattern.
  always_comb begin
    nibble_s    = 4'h0;
    dp_bit_s    = 1'b0;
    blank_bit_s = 1'b0;
    lz_bit_s    = 1'b0;
    an_s        = {NUM_DIGITS{1'b1}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_r == IW'(i)) begin
        nibble_s    = value_snap_r[4*i +: 4];
        dp_bit_s    = dp_snap_r[i];
        blank_bit_s = blank_snap_r[i];
        lz_bit_s    = lz_s[i];
        an_s[i]     = 1'b0;
      end else begin
        an_s[i]     = 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_SUPPRESS_EN
  // Suppression runs down from the top digit until a nonzero nibble or a lit dp.
  always_comb begin
    zero_run_s = 1'b1;
    lz_s       = {NUM_DIGITS{1'b0}};
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run_s = zero_run_s & (value_snap_r[4*i +: 4] == 4'h0) & ~dp_snap_r[i];
      if (i != 0) begin
        lz_s[i] = zero_run_s;
      end else begin
        lz_s[i] = 1'b0;
      end
    end
  end
`else
  // Without suppression only blank_mask darkens a digit.
  always_comb begin
    zero_run_s = 1'b0;
    lz_s       = {NUM_DIGITS{1'b0}};
  end
`endif

  // Hold counter, digit index and input snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r        <= {CW{1'b0}};
      idx_r        <= {IW{1'b0}};
      value_snap_r <= {(4*NUM_DIGITS){1'b0}};
      dp_snap_r    <= {NUM_DIGITS{1'b0}};
      blank_snap_r <= {NUM_DIGITS{1'b0}};
    end else if (!en) begin
      cnt_r        <= {CW{1'b0}};
      idx_r        <= {IW{1'b0}};
      value_snap_r <= value;
      dp_snap_r    <= dp_mask;
      blank_snap_r <= blank_mask;
    end else begin
      if (term_s) begin
        cnt_r <= {CW{1'b0}};
        idx_r <= (idx_r == IDX_MAX) ? {IW{1'b0}} : idx_r + IW'(1);
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
      // Fresh data only at a frame boundary so a frame never mixes two values.
      if (frame_end_s) begin
        value_snap_r <= value;
        dp_snap_r    <= dp_mask;
        blank_snap_r <= blank_mask;
      end else begin
        value_snap_r <= value_snap_r;
        dp_snap_r    <= dp_snap_r;
        blank_snap_r <= blank_snap_r;
      end
    end
  end

  // Registered display pins and frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n       <= {NUM_DIGITS{1'b1}};
      a_to_g_n   <= 7'h7F;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= en && frame_end_s;
      if (!en || blank_bit_s || lz_bit_s) begin
        an_n     <= {NUM_DIGITS{1'b1}};
        a_to_g_n <= 7'h7F;
        dp_n     <= 1'b1;
      end else begin
        an_n     <= an_s;
        a_to_g_n <= decode_hex(nibble_s);
        dp_n     <= ~dp_bit_s;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver (4 digits, hold 4) against a frame-position model.
module tb_seven_seg_scan_driver;

  localparam int N = 4;
  localparam int H = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [15:0]   value;
  logic [3:0]    dp_mask;
  logic [3:0]    blank_mask;
  logic [6:0]    a_to_g_n;
  logic          dp_n;
  logic [3:0]    an_n;
  logic          frame_tick;

  int tests = 0;
  int fails = 0;

  // Model state: position within the frame plus the snapshot
  int          pos;
  logic [15:0] snap_val;
  logic [3:0]  snap_dp;
  logic [3:0]  snap_blank;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic        exp_tick;

  logic [6:0] seg_tab [0:15] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  seven_seg_scan_driver #(.NUM_DIGITS(N), .DIGIT_HOLD_CYCLES(H)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .value(value), .dp_mask(dp_mask),
    .blank_mask(blank_mask), .a_to_g_n(a_to_g_n), .dp_n(dp_n), .an_n(an_n),
    .frame_tick(frame_tick));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic check_pins(input string tag);
    chk({tag, "/an_n"}, {12'h000, an_n}, {12'h000, exp_an});
    chk({tag, "/seg"}, {9'h000, a_to_g_n}, {9'h000, exp_seg});
    chk({tag, "/dp_n"}, {15'h0000, dp_n}, {15'h0000, exp_dp});
    chk({tag, "/tick"}, {15'h0000, frame_tick}, {15'h0000, exp_tick});
  endtask

  task automatic set_dark();
    exp_an  = 4'hF;
    exp_seg = 7'h7F;
    exp_dp  = 1'b1;
  endtask

  task automatic show_digit(input int d);
    logic [3:0] nib;
    logic       sup;
    nib = 4'((snap_val >> (4*d)) & 16'h000F);
    sup = 1'b0;
`ifdef LEADING_ZERO_SUPPRESS_EN
    sup = (d != 0);
    for (int j = d; j < N; j++) begin
      if (((snap_val >> (4*j)) & 16'h000F) != 16'h0000 || snap_dp[j]) sup = 1'b0;
    end
`endif
    if (snap_blank[d] || sup) begin
      set_dark();
    end else begin
      exp_an  = ~(4'b0001 << d);
      exp_seg = seg_tab[nib];
      exp_dp  = ~snap_dp[d];
    end
  endtask

  task automatic model_reset();
    pos        = 0;
    snap_val   = 16'h0000;
    snap_dp    = 4'h0;
    snap_blank = 4'h0;
    set_dark();
    exp_tick   = 1'b0;
  endtask

  // Advance the model with the current inputs, clock once, compare the pins.
  task automatic tick(input string tag);
    if (!rst_n) begin
      model_reset();
    end else if (!en) begin
      set_dark();
      exp_tick   = 1'b0;
      pos        = 0;
      snap_val   = value;
      snap_dp    = dp_mask;
      snap_blank = blank_mask;
    end else begin
      show_digit(pos / H);
      exp_tick = (pos == N*H - 1);
      if (pos == N*H - 1) begin
        pos        = 0;
        snap_val   = value;
        snap_dp    = dp_mask;
        snap_blank = blank_mask;
      end else begin
        pos++;
      end
    end
    @(posedge clk);
    #1;
    check_pins(tag);
  endtask

  initial begin
    rst_n      = 1'b0;
    en         = 1'b0;
    value      = 16'h12AF;
    dp_mask    = 4'h0;
    blank_mask = 4'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_pins("reset");
    rst_n = 1'b1;
    tick("idle");

    // Plain scan of 12AF
    en = 1'b1;
    repeat (2*N*H) tick("scan");

    // Value changes during digit 1; the frame in progress keeps the old data
    repeat (H + 1) tick("pre_change");
    value = 16'h0000;
    repeat (2*N*H) tick("snapshot");

    // Decimal point on digit 2, digit 0 blanked
    value      = 16'h8C3B;
    dp_mask    = 4'b0100;
    blank_mask = 4'b0001;
    repeat (2*N*H) tick("masks");

    // Drop enable during digit 2, then re-raise with a new value
    repeat (2*H + 1) tick("to_digit2");
    en = 1'b0;
    repeat (3) tick("en_off");
    value      = 16'h0040;
    dp_mask    = 4'h0;
    blank_mask = 4'h0;
    tick("en_off_load");
    en = 1'b1;
    repeat (N*H + 3) tick("en_on");
    value = 16'h0000;
    repeat (2*N*H) tick("zero");

    // Asynchronous reset mid-scan
    value = 16'h5E7D;
    repeat (N*H + 6) tick("pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_pins("async_reset");
    repeat (2) tick("in_reset");
    #2;
    rst_n = 1'b1;
    repeat (2*N*H) tick("post_reset");

    // Randomized inputs and enable toggling
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 24) == 0) en = ~en;
      if ($urandom_range(0, 9) == 0) value = 16'($urandom);
      if ($urandom_range(0, 3) == 0) value = value & 16'($urandom);
      if ($urandom_range(0, 11) == 0) dp_mask = 4'($urandom);
      if ($urandom_range(0, 11) == 0) blank_mask = 4'($urandom) & 4'($urandom);
      tick("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
